ifu: RTL and testbench
======================

# ifu

Instruction fetch unit for the single-cycle MIPS core. It owns the program counter, fetches each instruction word through a request/ready handshake to instruction memory, and holds that word in an instruction register for exactly one execute window. It presents the decoded fields (`op`, `funct`, register numbers, immediate) to the control decoder and datapath, and computes the next PC from the decoder's `Branch`/`Jump` outputs and the ALU `Zero` flag.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `imem_req` output 1: fetch request to instruction memory.
- `imem_addr` output 32: fetch address; always equals `pc`.
- `imem_ready` input 1: memory accepts the request; `imem_rdata` is valid in the same cycle.
- `imem_rdata` input 32: instruction word.
- `exec_hold` input 1: downstream stall; extends the execute window.
- `Branch` input 1: branch instruction (from decoder).
- `Zero` input 1: ALU equality result.
- `Jump` input 1: active-low; 0 means take the J-format jump.
- `pc` output 32: address of the current instruction.
- `link_pc` output 32: `pc + 4`, used as the JAL return value.
- `instr` output 32: instruction register.
- `op` output 6, `rs` output 5, `rt` output 5, `rd` output 5, `funct` output 6, `imm16` output 16: fields of `instr`.
- `instr_valid` output 1: the fields are valid; decoder outputs are meaningful.
- `commit` output 1: final execute cycle. Downstream gates RegWrite and MemWrite with this signal.

## Operation
- FSM states: FETCH, EXEC.
- Reset values:
  - state = FETCH
  - `pc` = RESET_PC
  - `instr` = 0 (nop)
  - `imem_req` = 0, `instr_valid` = 0, `commit` = 0
- FETCH:
  - `imem_req` = 1 while the FSM is in this state and reset is deasserted.
  - If `imem_ready` = 1: `instr` <= `imem_rdata`, then go to EXEC.
  - Otherwise stay in FETCH; `imem_addr` must remain stable.
- EXEC:
  - `instr_valid` = 1 and `imem_req` = 0.
  - `commit` = !`exec_hold`.
  - If `exec_hold` = 1: stay in EXEC; `pc` and `instr` are unchanged.
  - Otherwise `pc` <= next_pc, then go to FETCH.
- next_pc, highest priority first:
  - `Jump` == 0: {link_pc[31:28], instr[25:0], 2'b00}.
  - `Branch` && `Zero`: link_pc + (sign_extend(imm16) << 2).
  - Otherwise: link_pc.
- Arithmetic: all additions are 32-bit modulo 2^32, so 0xFFFF_FFFC + 4 wraps to 0. `pc[1:0]` is always 2'b00.
- `imem_ready` is ignored outside FETCH.
- `Branch`/`Zero`/`Jump` are sampled only on the commit edge.

## Timing
- Throughput: 2 cycles per instruction with `imem_ready` tied high (one FETCH, one EXEC).
- Each `imem_ready` wait cycle adds 1 cycle; each `exec_hold` cycle adds 1 cycle.
- Field outputs are combinational slices of `instr`. They are stable for the whole EXEC window and change only on the FETCH->EXEC edge.
- `commit` is high for exactly one cycle per instruction.
- Reset mid-fetch or mid-exec: outputs take their reset values immediately (asynchronous). The first request is issued in the first cycle after reset is released, with address RESET_PC.
- `Branch` and `Jump` both active: the jump wins.

## Structure
- Shared define file (alongside `ctrl_encode_def.v`) holds:
  - the FSM state encoding (FETCH = 1'b0, EXEC = 1'b1)
  - the default RESET_PC
  - the field bit positions
- Sub-module `npc`: purely combinational next-PC unit. Inputs: `pc`, `instr`, `Branch`, `Zero`, `Jump`. Outputs: `next_pc`, `link_pc`. `ifu` instantiates it once.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles, then release with `imem_ready`=1 → `pc`=0x3000; `imem_req` first high in the cycle after release; `instr_valid` in the following cycle; committed next `pc`=0x3004.
- **Memory wait:** `imem_ready` low for 3 cycles at 0x3004 → `imem_addr` stays 0x3004 with `imem_req` high throughout; instruction latched on the ready cycle; single EXEC follows.
- **Branch:** at pc 0x3004 with imm16=0xFFFF, `Branch`=1, `Zero`=1 → next `pc`=0x3004. With `Zero`=0 → next `pc`=0x3008.
- **Jump:** instr=0x0C00_0C00 at pc 0x3008 with `Jump`=0 (also set `Branch`=1, `Zero`=1 to check priority) → next `pc`=0x3000; `link_pc`=0x300C during EXEC.
- **Hold:** `exec_hold` high for 2 EXEC cycles → `instr_valid` high 3 cycles, `commit` high only in the 3rd, `pc` advances once.
- **Wrap and async reset:** RESET_PC=0xFFFF_FFFC, nop instruction → next `pc`=0x0000_0000. Then assert `reset` mid-EXEC → `instr_valid` and `commit` drop the same cycle and `pc` returns to RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, default
// reset vector, MIPS field positions and the branch offset helper.
package ifu_pkg;

    typedef logic [0:0] state_t;

    localparam state_t FETCH = 1'b0;
    localparam state_t EXEC  = 1'b1;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    localparam int OP_HI     = 31;
    localparam int OP_LO     = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;
    localparam int TARGET_HI = 25;
    localparam int TARGET_LO = 0;

    // Word offset of a conditional branch, sign-extended to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_npc.sv
// Combinational next-PC unit: sequential, branch and J-format jump targets.
module npc
    import ifu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    output logic [31:0] next_pc,
    output logic [31:0] link_pc
);

    logic unused_op;

    assign unused_op = ^instr[OP_HI:OP_LO];
    assign link_pc   = pc + 32'd4;

    // Jump is active-low and outranks a taken branch.
    always_comb begin
        next_pc = link_pc;
        if (!Jump)
            next_pc = {link_pc[31:28], instr[TARGET_HI:TARGET_LO], 2'b00};
        else if (Branch && Zero)
            next_pc = link_pc + branch_offset(instr[IMM_HI:IMM_LO]);
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches over a req/ready handshake and
// holds the instruction for one execute window (two states: FETCH, EXEC).
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        exec_hold,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    output logic [31:0] pc,
    output logic [31:0] link_pc,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic        instr_valid,
    output logic        commit
);

    state_t      state;
    logic [31:0] next_pc;

    npc u_npc (
        .pc      (pc),
        .instr   (instr),
        .Branch  (Branch),
        .Zero    (Zero),
        .Jump    (Jump),
        .next_pc (next_pc),
        .link_pc (link_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
            instr <= '0;
        end else if (state == FETCH) begin
            if (imem_ready) begin
                instr <= imem_rdata;
                state <= EXEC;
            end
        end else begin
            if (!exec_hold) begin
                pc    <= next_pc;
                state <= FETCH;
            end
        end
    end

    // Gating with reset keeps the request low while reset is held, even
    // though the state register already sits in FETCH.
    assign imem_req    = (state == FETCH) && reset;
    assign imem_addr   = pc;
    assign instr_valid = (state == EXEC);
    assign commit      = instr_valid && !exec_hold;

    assign op    = instr[OP_HI:OP_LO];
    assign rs    = instr[RS_HI:RS_LO];
    assign rt    = instr[RT_HI:RT_LO];
    assign rd    = instr[RD_HI:RD_LO];
    assign funct = instr[FUNCT_HI:FUNCT_LO];
    assign imm16 = instr[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a vector table of fetch/execute transactions plus
// hand-written reset, wrap-around and asynchronous-reset sequences.
module tb_ifu;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        exec_hold;
    logic        Branch;
    logic        Zero;
    logic        Jump;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] link_pc;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic        instr_valid;
    logic        commit;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_pc;
    logic [31:0] w_link_pc;
    logic [31:0] unused_w_instr;
    logic [5:0]  unused_w_op;
    logic [4:0]  unused_w_rs;
    logic [4:0]  unused_w_rt;
    logic [4:0]  unused_w_rd;
    logic [5:0]  unused_w_funct;
    logic [15:0] unused_w_imm16;
    logic        unused_w_valid;
    logic        unused_w_commit;

    typedef struct {
        logic [31:0] rdata;
        int          waits;
        int          holds;
        logic        br;
        logic        zr;
        logic        jp;
        logic [31:0] exp_pc;
        logic [31:0] exp_link;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ifu dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .exec_hold   (exec_hold),
        .Branch      (Branch),
        .Zero        (Zero),
        .Jump        (Jump),
        .pc          (pc),
        .link_pc     (link_pc),
        .instr       (instr),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .funct       (funct),
        .imm16       (imm16),
        .instr_valid (instr_valid),
        .commit      (commit)
    );

    ifu #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (w_imem_req),
        .imem_addr   (w_imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .exec_hold   (exec_hold),
        .Branch      (Branch),
        .Zero        (Zero),
        .Jump        (Jump),
        .pc          (w_pc),
        .link_pc     (w_link_pc),
        .instr       (unused_w_instr),
        .op          (unused_w_op),
        .rs          (unused_w_rs),
        .rt          (unused_w_rt),
        .rd          (unused_w_rd),
        .funct       (unused_w_funct),
        .imm16       (unused_w_imm16),
        .instr_valid (unused_w_valid),
        .commit      (unused_w_commit)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Enters at a point just after a falling edge with the DUT in FETCH and
    // leaves at the same phase with the next fetch pending.
    task automatic apply_stimulus(input vec_t v);
        check_output("fetch_req", 32'(imem_req), 32'd1);
        check_output("fetch_addr", imem_addr, v.exp_pc);
        for (int w = 0; w < v.waits; w++) begin
            imem_ready = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            #1;
            check_output("wait_req", 32'(imem_req), 32'd1);
            check_output("wait_addr", imem_addr, v.exp_pc);
            check_output("wait_valid", 32'(instr_valid), 32'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = v.rdata;
        Branch     = v.br;
        Zero       = v.zr;
        Jump       = v.jp;
        exec_hold  = (v.holds > 0);
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = 32'hBAAD_F00D;
        #1;
        check_output("exec_valid", 32'(instr_valid), 32'd1);
        check_output("exec_req", 32'(imem_req), 32'd0);
        check_output("exec_instr", instr, v.rdata);
        check_output("exec_op", 32'(op), 32'(v.rdata[31:26]));
        check_output("exec_rs", 32'(rs), 32'(v.rdata[25:21]));
        check_output("exec_rt", 32'(rt), 32'(v.rdata[20:16]));
        check_output("exec_rd", 32'(rd), 32'(v.rdata[15:11]));
        check_output("exec_funct", 32'(funct), 32'(v.rdata[5:0]));
        check_output("exec_imm16", 32'(imm16), 32'(v.rdata[15:0]));
        check_output("exec_link", link_pc, v.exp_link);
        for (int h = 0; h < v.holds; h++) begin
            check_output("hold_commit", 32'(commit), 32'd0);
            @(negedge clk);
            if (h == v.holds - 1)
                exec_hold = 1'b0;
            #1;
            check_output("hold_valid", 32'(instr_valid), 32'd1);
            check_output("hold_pc", pc, v.exp_pc);
            check_output("hold_instr", instr, v.rdata);
        end
        check_output("commit", 32'(commit), 32'd1);
        @(negedge clk);
        #1;
        check_output("next_pc", pc, v.exp_next);
        check_output("after_valid", 32'(instr_valid), 32'd0);
        check_output("after_commit", 32'(commit), 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h1000_FFFF, 3, 0, 1'b1, 1'b1, 1'b1, 32'h3004, 32'h3008, 32'h3004};
        vecs[1] = '{32'h1000_FFFF, 0, 0, 1'b1, 1'b0, 1'b1, 32'h3004, 32'h3008, 32'h3008};
        vecs[2] = '{32'h0C00_0C00, 0, 0, 1'b1, 1'b1, 1'b0, 32'h3008, 32'h300C, 32'h3000};
        vecs[3] = '{32'h012A_4020, 1, 2, 1'b0, 1'b1, 1'b1, 32'h3000, 32'h3004, 32'h3004};
        vecs[4] = '{32'h1000_0003, 0, 1, 1'b1, 1'b1, 1'b1, 32'h3004, 32'h3008, 32'h3014};

        reset      = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h0;
        exec_hold  = 1'b0;
        Branch     = 1'b0;
        Zero       = 1'b0;
        Jump       = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_output("rst_pc", pc, 32'h3000);
        check_output("rst_req", 32'(imem_req), 32'd0);
        check_output("rst_valid", 32'(instr_valid), 32'd0);
        check_output("rst_commit", 32'(commit), 32'd0);
        check_output("rst_instr", instr, 32'h0);
        check_output("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);

        reset = 1'b1;
        #1;
        check_output("first_req", 32'(imem_req), 32'd1);
        check_output("first_addr", imem_addr, 32'h3000);
        check_output("wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
        check_output("wrap_req", 32'(w_imem_req), 32'd1);
        @(negedge clk);
        #1;
        check_output("first_valid", 32'(instr_valid), 32'd1);
        check_output("first_commit", 32'(commit), 32'd1);
        check_output("first_link", link_pc, 32'h3004);
        check_output("wrap_link", w_link_pc, 32'h0);
        @(negedge clk);
        #1;
        check_output("first_next_pc", pc, 32'h3004);
        check_output("wrap_next_pc", w_pc, 32'h0);

        for (int i = 0; i < 5; i++)
            apply_stimulus(vecs[i]);

        // Reset arriving mid-EXEC must clear the outputs without a clock edge.
        imem_ready = 1'b1;
        imem_rdata = 32'h0;
        Jump       = 1'b1;
        Branch     = 1'b0;
        exec_hold  = 1'b0;
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        check_output("pre_rst_pc", pc, 32'h3014);
        check_output("pre_rst_commit", 32'(commit), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check_output("async_valid", 32'(instr_valid), 32'd0);
        check_output("async_commit", 32'(commit), 32'd0);
        check_output("async_pc", pc, 32'h3000);
        check_output("async_instr", instr, 32'h0);
        check_output("async_req", 32'(imem_req), 32'd0);
        check_output("async_wrap_pc", w_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("rerelease_req", 32'(imem_req), 32'd1);
        check_output("rerelease_addr", imem_addr, 32'h3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
